// File: rtl/config_chain_loader_pkg.sv
// Shared types and helpers for the configuration chain loader.
// The state enum is used by the top FSM; the helpers size the words of the bitstream.
package config_chain_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHIFT = 3'd2,
        SET   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int unsigned DEF_CHAIN_LEN = 1024;
    localparam int unsigned DEF_WORD_W    = 32;

    function automatic int unsigned num_words(input int unsigned chain_len,
                                              input int unsigned word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    localparam int unsigned NUM_WORDS = num_words(DEF_CHAIN_LEN, DEF_WORD_W);

    // Bits to shift from the next word: the final word of an unaligned chain is partial.
    function automatic int unsigned word_take(input int unsigned bits_left,
                                              input int unsigned word_w);
        return (bits_left < word_w) ? bits_left : word_w;
    endfunction

endpackage

// File: rtl/config_word_serializer.sv
// Holds one bitstream word and emits it LSB first, one bit per shift.
// last is high while the final valid bit of the word is on bit_out.
module config_word_serializer #(
    parameter int WORD_W = 32,
    parameter int NB_W   = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] data,
    input  logic [NB_W-1:0]   nbits,
    input  logic              shift,
    output logic              bit_out,
    output logic              last
);

    logic [WORD_W-1:0] shreg;
    logic [NB_W-1:0]   word_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            word_bits <= '0;
        end else if (load) begin
            shreg     <= data;
            word_bits <= nbits;
        end else if (shift) begin
            shreg     <= shreg >> 1;
            word_bits <= word_bits - 1'b1;
        end
    end

    assign bit_out = shreg[0];
    assign last    = (word_bits == NB_W'(1));

endmodule

// File: rtl/config_chain_loader.sv
// Streams a bitstream into the fabric configuration chain and commits it with a set pulse.
// Outputs are decoded from the state so a reset clears them all on the following cycle.
module config_chain_loader
    import config_chain_loader_pkg::*;
#(
    parameter int CHAIN_LEN  = 1024,
    parameter int WORD_W     = 32,
    parameter int SET_CYCLES = 2,
    parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cen,
    output logic              shift_in,
    output logic              set_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bits_left
);

    localparam int NB_W = $clog2(WORD_W + 1);
    localparam int SC_W = $clog2(SET_CYCLES + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] bits_cnt;
    logic [SC_W-1:0]  set_cnt;
    logic [NB_W-1:0]  take;
    logic             load, shift, ser_bit, ser_last;

    assign take  = NB_W'(word_take(32'(bits_cnt), WORD_W));
    assign load  = (state == FETCH) && in_valid;
    assign shift = (state == SHIFT);

    config_word_serializer #(
        .WORD_W (WORD_W),
        .NB_W   (NB_W)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .data    (in_data),
        .nbits   (take),
        .shift   (shift),
        .bit_out (ser_bit),
        .last    (ser_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bits_cnt <= '0;
            set_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start)
                bits_cnt <= CNT_W'(CHAIN_LEN);
            else if (shift)
                bits_cnt <= bits_cnt - 1'b1;
            set_cnt <= (state == SET) ? set_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = FETCH;
            FETCH: if (in_valid) state_nxt = SHIFT;
            // bits_cnt still counts the bit going out this cycle
            SHIFT: if (ser_last) state_nxt = (bits_cnt == CNT_W'(1)) ? SET : FETCH;
            SET:   if (set_cnt == SC_W'(SET_CYCLES - 1)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == FETCH);
    assign cen       = (state == SHIFT);
    assign shift_in  = (state == SHIFT) && ser_bit;
    assign set_out   = (state == SET);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign bits_left = bits_cnt;

endmodule

// File: tb/tb_config_chain_loader.sv
// Self-checking bench: a 70-bit/32-bit loader driven with random words and stalls,
// plus an 8-bit/8-bit instance for the single-word case.
module tb_config_chain_loader;

    localparam int L  = 70;
    localparam int W  = 32;
    localparam int S  = 2;
    localparam int CW = $clog2(L + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready, cen, shift_in, set_out, busy, done;
    logic [CW-1:0] bits_left;

    logic          s_start, s_in_valid;
    logic [7:0]    s_in_data;
    logic          s_in_ready, s_cen, s_shift_in, s_set_out, s_busy, s_done;
    logic [3:0]    s_bits_left;

    config_chain_loader #(.CHAIN_LEN(L), .WORD_W(W), .SET_CYCLES(S), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .cen(cen), .shift_in(shift_in), .set_out(set_out),
        .busy(busy), .done(done), .bits_left(bits_left));

    config_chain_loader #(.CHAIN_LEN(8), .WORD_W(8), .SET_CYCLES(2), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .in_data(s_in_data), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .cen(s_cen), .shift_in(s_shift_in), .set_out(s_set_out),
        .busy(s_busy), .done(s_done), .bits_left(s_bits_left));

    int total = 0;
    int bad   = 0;

    // Observer of the big instance: collects the serial stream and models the chain.
    logic         mon_clr;
    logic         mon_bits [0:255];
    int           nbits, set_cyc, set_pulses, done_cnt, viol;
    logic [L-1:0] chain, latched;
    logic         set_prev;

    initial begin
        chain   = '0;
        latched = '0;
    end

    always @(negedge clk) begin
        if (mon_clr) begin
            nbits <= 0; set_cyc <= 0; set_pulses <= 0; done_cnt <= 0; viol <= 0;
            set_prev <= 1'b0;
        end else begin
            if (cen) begin
                if (nbits < 256) mon_bits[nbits] <= shift_in;
                nbits <= nbits + 1;
                chain <= {chain[L-2:0], shift_in};
                if (set_out || bits_left != CW'(L - nbits)) viol <= viol + 1;
            end else if (shift_in) begin
                viol <= viol + 1;
            end
            if (set_out) begin
                set_cyc <= set_cyc + 1;
                latched <= chain;
                if (bits_left != '0) viol <= viol + 1;
            end
            if (set_out && !set_prev) set_pulses <= set_pulses + 1;
            if (done) done_cnt <= done_cnt + 1;
            set_prev <= set_out;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream bit i comes from word i/W, bit i%W; the tail of the last word is dropped.
    function automatic logic [L-1:0] model_stream(input logic [W-1:0] w0, w1, w2);
        logic [3*W-1:0] cat;
        cat = {w2, w1, w0};
        return cat[L-1:0];
    endfunction

    task automatic load_and_check(input string tag, input logic [W-1:0] w0, w1, w2,
                                  input int stall_len, input bit poke,
                                  output logic [L-1:0] got);
        logic [W-1:0] words [3];
        logic [L-1:0] exp_s, exp_chain;
        int  wi, stall, stall_seen, stall_bad, cycles, ncen;
        bit  hs, poke_now, finished;
        words = '{w0, w1, w2};
        wi = 0; stall = stall_len; stall_seen = 0; stall_bad = 0; cycles = 0; ncen = 0;
        finished = 1'b0; poke_now = 1'b0;
        mon_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 400; c++) begin
            in_data  = words[(wi < 3) ? wi : 2];
            in_valid = (wi < 3) && !(wi == 2 && stall > 0);
            @(negedge clk);
            cycles++;
            hs = in_valid && in_ready;
            if (cen) ncen++;
            if (in_ready && wi == 2 && stall > 0) begin
                stall--;
                stall_seen++;
                if (cen) stall_bad++;
            end
            poke_now = poke && ((cen && ncen == 20) || set_out);
            finished = done;
            @(posedge clk); #1;
            start = poke_now;
            if (hs) wi++;
            if (finished) break;
        end
        start = 1'b0; in_valid = 1'b0;
        check({tag, "_timeout"}, !finished, 0);
        check({tag, "_cycles"}, cycles, 1 + 3 + L + S + 1 + stall_len);
        check({tag, "_stall"}, {stall_seen[7:0], stall_bad[7:0]}, {stall_len[7:0], 8'd0});
        check({tag, "_ncen"}, nbits, L);
        for (int i = 0; i < L; i++) got[i] = mon_bits[i];
        exp_s = model_stream(w0, w1, w2);
        check({tag, "_stream"}, got, exp_s);
        for (int i = 0; i < L; i++) exp_chain[L-1-i] = exp_s[i];
        check({tag, "_chain"}, latched, exp_chain);
        check({tag, "_set"}, {set_cyc[7:0], set_pulses[7:0], done_cnt[7:0]}, {8'(S), 8'd1, 8'd1});
        check({tag, "_viol"}, viol, 0);
        check({tag, "_idle"}, {busy, in_ready, cen}, 3'b000);
    endtask

    initial begin
        logic [L-1:0] g0, g1;
        logic [7:0]   seq;
        int nsh, first_c, last_c, set_n, done_n, done_c, ncen;
        bit busy_done, busy_after, prev_done;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; mon_clr = 1'b1;
        s_start = 1'b0; s_in_valid = 1'b0; s_in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_big", {in_ready, cen, shift_in, set_out, busy, done, bits_left},
              '0);
        check("reset_small", {s_in_ready, s_cen, s_shift_in, s_set_out, s_busy, s_done, s_bits_left},
              '0);
        @(posedge clk); #1;
        rst = 1'b0; mon_clr = 1'b0;

        // Single 8-bit word: 0xA5 goes out LSB first
        s_start = 1'b1; s_in_data = 8'hA5;
        seq = '0; nsh = 0; first_c = -1; last_c = -1; set_n = 0; done_n = 0; done_c = -1;
        busy_done = 1'b0; busy_after = 1'b1; prev_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (prev_done) busy_after = s_busy;
            if (s_cen) begin
                if (nsh < 8) seq[nsh] = s_shift_in;
                nsh++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (s_set_out) set_n++;
            if (s_done) begin done_n++; done_c = c; busy_done = s_busy; end
            prev_done = s_done;
            @(posedge clk); #1;
            s_start = 1'b0;
            s_in_valid = (c == 0);
        end
        check("small_seq", seq, 8'hA5);
        check("small_ncen", nsh, 8);
        check("small_contig", last_c - first_c + 1, 8);
        check("small_set", set_n, 2);
        check("small_done", {done_n[7:0], done_c[7:0]}, {8'd1, 8'd12});
        check("small_busy", {busy_done, busy_after}, 2'b10);

        // Directed bitstream, then the same with a 5-cycle stall before word 2
        load_and_check("dir", 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFC5, 0, 1'b0, g0);
        check("dir_tail", g0[L-1:L-6], 6'b000101);
        load_and_check("stall", 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFC5, 5, 1'b0, g1);
        check("stall_same", g1, g0);

        load_and_check("rnd_poke", $urandom, $urandom, $urandom, 0, 1'b1, g0);
        load_and_check("rnd_stall", $urandom, $urandom, $urandom, $urandom_range(1, 6), 1'b1, g0);

        // Reset on the 40th shift cycle aborts without committing
        mon_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0;
        start = 1'b1; in_valid = 1'b1; in_data = $urandom; ncen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (cen) ncen++;
            if (ncen == 40) break;
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("rst_reach", ncen, 40);
        rst = 1'b1;
        @(negedge clk);
        check("rst_outs", {in_ready, cen, shift_in, set_out, busy, done, bits_left}, '0);
        check("rst_noset", set_pulses, 0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; start = 1'b0;
        load_and_check("after_rst", $urandom, $urandom, $urandom, 0, 1'b0, g0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
